// File: rtl/stream_xor_ctrl.sv
// stream_xor_ctrl: XORs a plaintext nibble stream with a 4-nibble keystream
// block fetched from an external generator addressed by a 2-bit block counter.
module stream_xor_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] ctr_init,
  output logic [1:0] ks_counter,
  input  logic [3:0] ks_word1,
  input  logic [3:0] ks_word2,
  input  logic [3:0] ks_word3,
  input  logic [3:0] ks_word4,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic       ctr_wrap
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx;
  logic [15:0] blk;      // {word4, word3, word2, word1}
  logic        start_acc;
  logic        in_acc;
  logic        blk_end;  // 4th nibble of a block accepted and message continues
  logic [3:0]  ks_sel;

  assign start_acc = (state == IDLE) && start;
  assign in_ready  = (state == STREAM) && (!out_valid || out_ready);
  assign in_acc    = in_valid && in_ready;
  assign blk_end   = in_acc && !in_last && (idx == 2'd3);
  assign busy      = (state != IDLE);
  assign ks_sel    = blk[{idx, 2'b00} +: 4];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start_acc) state_nxt = LOAD;
      LOAD:   state_nxt = STREAM;
      STREAM: begin
        if (in_acc && in_last) state_nxt = IDLE;
        else if (blk_end)      state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter, nibble index, wrap flag and keystream block capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_counter <= 2'd0;
      idx        <= 2'd0;
      ctr_wrap   <= 1'b0;
      blk        <= 16'd0;
    end else begin
      if (start_acc) begin
        ks_counter <= ctr_init;
        idx        <= 2'd0;
        ctr_wrap   <= 1'b0;
      end
      if (state == LOAD)
        blk <= {ks_word4, ks_word3, ks_word2, ks_word1};
      if (in_acc) begin
        // A last nibble ends the message without advancing the counter;
        // leftover keystream words of the block are simply dropped.
        if (in_last) begin
          idx <= 2'd0;
        end else if (idx == 2'd3) begin
          idx        <= 2'd0;
          ks_counter <= ks_counter + 2'd1;
          if (ks_counter == 2'd3) ctr_wrap <= 1'b1;
        end else begin
          idx <= idx + 2'd1;
        end
      end
    end
  end

  // Output register: a new accept overwrites, otherwise drain on out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 4'd0;
      out_last  <= 1'b0;
    end else if (in_acc) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ ks_sel;
      out_last  <= in_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_xor_ctrl.sv
// tb_stream_xor_ctrl: randomized scoreboard bench for stream_xor_ctrl.
module tb_stream_xor_ctrl;

  logic       clk, rst_n, start;
  logic [1:0] ctr_init, ks_counter;
  logic [3:0] ks_word1, ks_word2, ks_word3, ks_word4;
  logic       in_valid, in_last, in_ready;
  logic [3:0] in_data, out_data;
  logic       out_valid, out_last, out_ready, busy, ctr_wrap;

  stream_xor_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ctr_init(ctr_init),
    .ks_counter(ks_counter),
    .ks_word1(ks_word1), .ks_word2(ks_word2), .ks_word3(ks_word3), .ks_word4(ks_word4),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .ctr_wrap(ctr_wrap)
  );

  // Keystream generator stand-in: a table indexed by counter, word
  logic [3:0] ks_tab [4][4];
  always_comb begin
    ks_word1 = ks_tab[ks_counter][0];
    ks_word2 = ks_tab[ks_counter][1];
    ks_word3 = ks_tab[ks_counter][2];
    ks_word4 = ks_tab[ks_counter][3];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] d;
    logic       l;
    int         c;   // cycle of the accepting negedge sample
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] fixed_q[$];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake
  initial begin
    bit         held = 0;
    logic [3:0] hd = 0;
    logic       hl = 0;
    int         first = -1;
    exp_t       e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 0; first = -1;
        continue;
      end
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (held) chk("out_stable", {out_data, out_last}, {hd, hl});
        if (out_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_last", out_last, e.l);
            chk("out_latency", first, e.c + 1);
          end
          first = -1; held = 0;
        end else begin
          held = 1; hd = out_data; hl = out_last;
        end
      end else begin
        held = 0; first = -1;
      end
    end
  end

  // One message of n nibbles from block counter c.
  // mode 0: free flow; 1: random gaps/backpressure plus stray starts;
  // 2: out_ready held low for 3 cycles after the first accept.
  task automatic run_msg(input logic [1:0] c, input int n, input int mode, input bit pre);
    logic [3:0] dat [16];
    int  idx = 0, stall = 0, hold = -1, b;
    bit  exp_load = 0;
    for (int i = 0; i < n; i++)
      dat[i] = (i < fixed_q.size()) ? fixed_q[i] : 4'($urandom);
    if (!pre) begin
      @(negedge clk); start = 1; ctr_init = c;
      #1 chk("idle_before_start", busy, 0);
      @(negedge clk); start = 0;
      #1 chk("load_after_start", {busy, in_ready}, 2'b10);
    end
    while (idx < n) begin
      @(negedge clk);
      in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = dat[idx];
      in_last  = (idx == n - 1);
      start    = (mode == 1) && ($urandom_range(0, 5) == 0);
      ctr_init = 2'($urandom);
      case (mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = !(hold >= 0 && hold < 3);
        default: out_ready = 1'b1;
      endcase
      #1;
      if (exp_load) begin
        chk("load_gap", in_ready, 0);
        exp_load = 0;
      end
      if (mode == 2 && hold >= 0 && hold < 3) chk("bp_stall", in_ready, 0);
      if (mode == 2 && hold == 3 && n > 1)    chk("bp_resume", in_ready, 1);
      if (hold >= 0) hold++;
      if (in_valid && in_ready) begin
        b = int'(c) + idx / 4;
        chk("ks_counter", ks_counter, b % 4);
        chk("ctr_wrap", ctr_wrap, (b >= 4) ? 1 : 0);
        sbq.push_back('{dat[idx] ^ ks_tab[b % 4][idx % 4], in_last, cyc});
        if (mode == 2 && hold < 0) hold = 0;
        idx++;
        stall = 0;
        if (idx % 4 == 0 && idx < n) exp_load = 1;
      end else if (++stall > 40) begin
        chk("accept_timeout", stall, 0);
        break;
      end
    end
    @(negedge clk);
    in_valid = 0; in_last = 0; start = 0; out_ready = 1;
    #1;
    chk("idle_after_msg", busy, 0);
    chk("ctr_final", ks_counter, (int'(c) + (n - 1) / 4) % 4);
  endtask

  // Reset in the middle of a message with an output pending
  task automatic reset_test();
    @(negedge clk); start = 1; ctr_init = 2'($urandom);
    @(negedge clk); start = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1; in_data = 4'($urandom); in_last = 0; out_ready = 0;
      #1;
      if (in_ready) break;
    end
    @(negedge clk); in_valid = 0;
    #1 chk("pending_before_rst", {out_valid, busy}, 2'b11);
    #2 rst_n = 0;
    #1;
    chk("async_rst_out", {out_valid, out_data, out_last}, 0);
    chk("async_rst_ctl", {in_ready, busy, ctr_wrap, ks_counter}, 0);
    sbq.delete();
    @(negedge clk);
    out_ready = 1; in_valid = 1; in_last = 1;
    #3 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("quiet_after_rst", {out_valid, in_ready, busy}, 0);
    end
    in_valid = 0; in_last = 0;
  endtask

  initial begin
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) ks_tab[c][w] = 4'($urandom);
    ks_tab[1][0] = 4'hA; ks_tab[1][1] = 4'h3; ks_tab[1][2] = 4'hC; ks_tab[1][3] = 4'h5;
    rst_n = 0; start = 0; ctr_init = 0;
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 1;
    #2 chk("reset_state", {out_valid, out_data, out_last, in_ready, busy, ctr_wrap, ks_counter}, 0);

    // Start already high across reset release: taken on the first edge
    @(negedge clk); start = 1; ctr_init = 1;
    #3 rst_n = 1;
    @(negedge clk);
    #1 chk("start_first_edge", {busy, in_ready}, 2'b10);
    start = 0;
    fixed_q = '{4'h0, 4'hF, 4'h1, 4'h2};
    run_msg(2'd1, 4, 0, 1'b1);          // expects A,C,D,7
    fixed_q.delete();

    run_msg(2'd3, 6, 0, 1'b0);          // crosses a block, counter wraps
    run_msg(2'($urandom), 5, 2, 1'b0);  // backpressure
    run_msg(2'd0, 2, 0, 1'b0);          // early last
    for (int w = 0; w < 4; w++) ks_tab[2][w] = 4'($urandom);
    run_msg(2'd2, 3, 0, 1'b0);          // fresh keystream, index restarts
    reset_test();
    for (int k = 0; k < 25; k++)
      run_msg(2'($urandom), $urandom_range(1, 12), $urandom_range(0, 2), 1'b0);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    #3 chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
